// File: rtl/draw_command_queue.sv
// Rectangle-fill command FIFO with a three-state dispatcher feeding the square-draw stage.
// Define DRAW_QUEUE_CLIP_EN to clip commands to the LCD (and drop off-screen ones) at enqueue.
module draw_command_queue #(
   parameter int DEPTH      = 8,
   parameter int LCD_WIDTH  = 240,
   parameter int LCD_HEIGHT = 320
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       cmdValid,
   output logic                       cmdReady,
   input  logic [7:0]                 cmdX,
   input  logic [8:0]                 cmdY,
   input  logic [7:0]                 cmdWidth,
   input  logic [8:0]                 cmdHeight,
   input  logic [15:0]                cmdColour,
   output logic                       drawStart,
   output logic [7:0]                 drawXOrigin,
   output logic [8:0]                 drawYOrigin,
   output logic [7:0]                 drawWidth,
   output logic [8:0]                 drawHeight,
   output logic [15:0]                drawPixelData,
   input  logic                       drawReady,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [7:0]                 dropCount
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

   state_t        state, state_next;
   logic [49:0]   mem [DEPTH];
   logic [49:0]   head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_next;
   logic          accept, push, pop;
   logic          cmd_drop;
   logic [7:0]    store_width;
   logic [8:0]    store_height;

`ifdef DRAW_QUEUE_CLIP_EN
   // Only meaningful when x is on-screen; off-screen commands are dropped anyway.
   function automatic logic [7:0] clip_width(input logic [7:0] x, input logic [7:0] w);
      logic [8:0] room;
      room = 9'(LCD_WIDTH) - {1'b0, x};
      if ({1'b0, w} > room) return room[7:0];
      return w;
   endfunction

   function automatic logic [8:0] clip_height(input logic [8:0] y, input logic [8:0] h);
      logic [9:0] room;
      room = 10'(LCD_HEIGHT) - {1'b0, y};
      if ({1'b0, h} > room) return room[8:0];
      return h;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      if (v == 8'hFF) return v;
      return v + 8'd1;
   endfunction

   always_comb begin
      cmd_drop     = ({1'b0, cmdX} >= 9'(LCD_WIDTH)) || ({1'b0, cmdY} >= 10'(LCD_HEIGHT)) ||
                     (cmdWidth == 8'd0) || (cmdHeight == 9'd0);
      store_width  = clip_width(cmdX, cmdWidth);
      store_height = clip_height(cmdY, cmdHeight);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         dropCount <= 8'd0;
      else if (accept && cmd_drop)
         dropCount <= sat_inc8(dropCount);
   end
`else
   always_comb begin
      cmd_drop     = 1'b0;
      store_width  = cmdWidth;
      store_height = cmdHeight;
   end

   assign dropCount = 8'd0;
`endif

   assign accept = cmdValid && cmdReady;
   assign push   = accept && !cmd_drop;
   assign head   = mem[rd_ptr];

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // FIFO storage: data only, the pointers and count carry the state.
   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= {cmdX, cmdY, store_width, store_height, cmdColour};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         cmdReady <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count    <= count_next;
         cmdReady <= (count_next != FULL_COUNT);
      end
   end

   // Dispatcher: state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (pop)        state_next = ISSUE;
         ISSUE:     if (!drawReady) state_next = WAIT_DONE;
         WAIT_DONE: if (drawReady)  state_next = IDLE;
         default:                   state_next = IDLE;
      endcase
   end

   always_comb begin
      pop = (state == IDLE) && (count != '0) && drawReady;
   end

   // Drawer-facing registers: loaded on pop, held through ISSUE and WAIT_DONE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         drawStart     <= 1'b0;
         drawXOrigin   <= '0;
         drawYOrigin   <= '0;
         drawWidth     <= '0;
         drawHeight    <= '0;
         drawPixelData <= '0;
      end else begin
         drawStart <= (state_next == ISSUE);
         if (pop)
            {drawXOrigin, drawYOrigin, drawWidth, drawHeight, drawPixelData} <= head;
      end
   end

endmodule
